// File: rtl/dice_input_conditioner.sv
// Synchronizes, debounces and arbitrates the two dice "roll" buttons into
// mutually exclusive ER/EL enables plus a conflict flag for the game FSM.
module dice_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_r_raw,
  input  logic btn_l_raw,
  output logic ER,
  output logic EL,
  output logic conflict
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2,
    LOCK  = 2'd3
  } state_t;

  // Bit 0 is the right button, bit 1 the left button.
  logic [1:0]    w_raw;
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_stable;
  logic [CW-1:0] r_cnt [2];
  state_t        r_state;
  state_t        w_next;
  logic          w_rb;
  logic          w_lb;

  assign w_raw = {btn_l_raw, btn_r_raw};
  assign w_rb  = r_stable[0];
  assign w_lb  = r_stable[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stable <= '0;
      for (int c = 0; c < 2; c++) r_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (r_s2[c] == r_stable[c]) begin
          r_cnt[c] <= '0;
        end else if (r_cnt[c] == CNT_MAX) begin
          r_stable[c] <= r_s2[c];
          r_cnt[c]    <= '0;
        end else begin
          r_cnt[c] <= r_cnt[c] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // The owner keeps its grant while held; any overlap ends in LOCK until both release.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE: begin
        if (w_rb && w_lb)       w_next = LOCK;
        else if (w_rb)          w_next = RIGHT;
        else if (w_lb)          w_next = LEFT;
        else                    w_next = IDLE;
      end
      RIGHT: begin
        if (w_rb)               w_next = RIGHT;
        else if (w_lb)          w_next = LOCK;
        else                    w_next = IDLE;
      end
      LEFT: begin
        if (w_lb)               w_next = LEFT;
        else if (w_rb)          w_next = LOCK;
        else                    w_next = IDLE;
      end
      LOCK: begin
        if (!w_rb && !w_lb)     w_next = IDLE;
        else                    w_next = LOCK;
      end
      default:                  w_next = IDLE;
    endcase
  end

  assign ER       = (r_state == RIGHT);
  assign EL       = (r_state == LEFT);
  assign conflict = (r_state == LOCK);

endmodule

// File: tb/tb_dice_input_conditioner.sv
// Bench for dice_input_conditioner: directed latency/arbitration cases plus
// randomized bouncing, all compared against a behavioural model every cycle.
module tb_dice_input_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_r_raw = 1'b0;
  logic btn_l_raw = 1'b0;
  logic ER, EL, conflict;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  dice_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .reset(reset),
    .btn_r_raw(btn_r_raw),
    .btn_l_raw(btn_l_raw),
    .ER(ER),
    .EL(EL),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic act, logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
  endfunction

  // Behavioural model: raw value reaches the debouncer two edges later; a
  // debounced level follows it once it has disagreed for D edges in a row.
  // owner: 0 nobody, 1 right granted, 2 left granted, 3 locked out.
  bit m_pipe_r [2];
  bit m_pipe_l [2];
  bit m_deb_r = 0, m_deb_l = 0;
  int m_dis_r = 0, m_dis_l = 0;
  int m_owner = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pipe_r = '{0, 0};
      m_pipe_l = '{0, 0};
      m_deb_r  = 0;
      m_deb_l  = 0;
      m_dis_r  = 0;
      m_dis_l  = 0;
      m_owner  = 0;
    end else begin
      case (m_owner)
        0: m_owner = (m_deb_r && m_deb_l) ? 3 : m_deb_r ? 1 : m_deb_l ? 2 : 0;
        1: if (!m_deb_r) m_owner = m_deb_l ? 3 : 0;
        2: if (!m_deb_l) m_owner = m_deb_r ? 3 : 0;
        default: if (!m_deb_r && !m_deb_l) m_owner = 0;
      endcase
      m_dis_r = (m_pipe_r[1] != m_deb_r) ? m_dis_r + 1 : 0;
      if (m_dis_r == D) begin m_deb_r = m_pipe_r[1]; m_dis_r = 0; end
      m_dis_l = (m_pipe_l[1] != m_deb_l) ? m_dis_l + 1 : 0;
      if (m_dis_l == D) begin m_deb_l = m_pipe_l[1]; m_dis_l = 0; end
      m_pipe_r[1] = m_pipe_r[0];  m_pipe_r[0] = btn_r_raw;
      m_pipe_l[1] = m_pipe_l[0];  m_pipe_l[0] = btn_l_raw;
    end
  end

  // Raw sample history, indexed by edge number, for the grant-preceded-by-stability property.
  int ecnt = 0;
  bit hist_r [64];
  bit hist_l [64];
  always @(posedge clk) begin
    ecnt++;
    hist_r[ecnt & 63] = btn_r_raw;
    hist_l[ecnt & 63] = btn_l_raw;
  end

  logic er_prev = 1'b0, el_prev = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      bit ok_r, ok_l;
      chk("ER_model", ER, m_owner == 1);
      chk("EL_model", EL, m_owner == 2);
      chk("conflict_model", conflict, m_owner == 3);
      chk("ER_EL_exclusive", ER & EL, 1'b0);
      if (ER && !er_prev && ecnt >= D + 3) begin
        ok_r = 1;
        for (int i = 0; i < D; i++) if (!hist_r[(ecnt - 3 - i) & 63]) ok_r = 0;
        chk("ER_rise_stable_history", ok_r, 1'b1);
      end
      if (EL && !el_prev && ecnt >= D + 3) begin
        ok_l = 1;
        for (int i = 0; i < D; i++) if (!hist_l[(ecnt - 3 - i) & 63]) ok_l = 0;
        chk("EL_rise_stable_history", ok_l, 1'b1);
      end
    end
    er_prev = ER;
    el_prev = EL;
  end

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int rem_r, rem_l;
    edges(3);
    chk("reset_ER", ER, 1'b0);
    chk("reset_EL", EL, 1'b0);
    chk("reset_conflict", conflict, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cmp_en = 1'b1;

    // Clean right press and release: D+3 edges each way.
    @(negedge clk); btn_r_raw = 1'b1;
    edges(6);  chk("press_ER_edge6", ER, 1'b0);
    edges(1);  chk("press_ER_edge7", ER, 1'b1);
    edges(20); chk("hold_ER", ER, 1'b1);
    chk("hold_EL", EL, 1'b0);
    chk("hold_conflict", conflict, 1'b0);
    @(negedge clk); btn_r_raw = 1'b0;
    edges(6);  chk("release_ER_edge6", ER, 1'b1);
    edges(1);  chk("release_ER_edge7", ER, 1'b0);
    edges(4);

    // Bounce rejection on left, then a real press.
    @(negedge clk); btn_l_raw = 1'b1;
    repeat (3) @(negedge clk); btn_l_raw = 1'b0;
    repeat (2) @(negedge clk); btn_l_raw = 1'b1;
    repeat (3) @(negedge clk); btn_l_raw = 1'b0;
    edges(12); chk("bounce_EL", EL, 1'b0);
    chk("bounce_conflict", conflict, 1'b0);
    @(negedge clk); btn_l_raw = 1'b1;
    edges(6);  chk("lpress_EL_edge6", EL, 1'b0);
    edges(1);  chk("lpress_EL_edge7", EL, 1'b1);
    @(negedge clk); btn_l_raw = 1'b0;
    edges(10); chk("lrelease_EL", EL, 1'b0);

    // Cross press: R owns, L ignored, releasing R locks out.
    @(negedge clk); btn_r_raw = 1'b1;
    edges(7);  chk("cross_ER_grant", ER, 1'b1);
    @(negedge clk); btn_l_raw = 1'b1;
    edges(10); chk("cross_ER_kept", ER, 1'b1);
    chk("cross_EL_blocked", EL, 1'b0);
    @(negedge clk); btn_r_raw = 1'b0;
    edges(7);  chk("cross_ER_off", ER, 1'b0);
    chk("cross_lock", conflict, 1'b1);
    chk("cross_EL_still0", EL, 1'b0);
    @(negedge clk); btn_l_raw = 1'b0;
    edges(6);  chk("cross_lock_edge6", conflict, 1'b1);
    edges(1);  chk("cross_unlock_edge7", conflict, 1'b0);
    chk("cross_EL_end", EL, 1'b0);

    // Simultaneous press goes straight to LOCK.
    @(negedge clk); btn_r_raw = 1'b1; btn_l_raw = 1'b1;
    edges(7);  chk("simul_conflict", conflict, 1'b1);
    chk("simul_ER", ER, 1'b0);
    chk("simul_EL", EL, 1'b0);
    @(negedge clk); btn_r_raw = 1'b0; btn_l_raw = 1'b0;
    edges(7);  chk("simul_release", conflict, 1'b0);

    // Asynchronous reset mid-grant, then re-detection through the full path.
    @(negedge clk); btn_r_raw = 1'b1;
    edges(7);  chk("rst_pre_ER", ER, 1'b1);
    #1 reset = 1'b0;
    #1 chk("rst_async_ER", ER, 1'b0);
    edges(1);
    @(negedge clk); reset = 1'b1;
    edges(6);  chk("rst_redetect_edge6", ER, 1'b0);
    edges(1);  chk("rst_redetect_edge7", ER, 1'b1);
    @(negedge clk); btn_r_raw = 1'b0;
    edges(10);

    // Randomized bouncing on both buttons with random run lengths.
    rem_r = 0;
    rem_l = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (rem_r == 0) begin
        btn_r_raw = 1'($urandom_range(0, 1));
        rem_r = $urandom_range(1, 12);
      end else rem_r--;
      if (rem_l == 0) begin
        btn_l_raw = 1'($urandom_range(0, 1));
        rem_l = $urandom_range(1, 12);
      end else rem_l--;
    end
    @(negedge clk); btn_r_raw = 1'b0; btn_l_raw = 1'b0;
    edges(10);
    chk("final_idle_ER", ER, 1'b0);
    chk("final_idle_EL", EL, 1'b0);
    chk("final_idle_conflict", conflict, 1'b0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
